// File: rtl/rc4_mem_sequencer.sv
// Sequencer for the RC4 S-memory phases (init, KSA, PRGA): issues one-cycle start
// pulses in order, waits on each finish under a watchdog, and owns the shared write port.
module rc4_mem_sequencer #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    output logic              error,
    output logic [1:0]        phase,
    output logic              init_start,
    output logic              ksa_start,
    output logic              prga_start,
    input  logic              init_finish,
    input  logic              ksa_finish,
    input  logic              prga_finish,
    input  logic [ADDR_W-1:0] init_address,
    input  logic [ADDR_W-1:0] ksa_address,
    input  logic [ADDR_W-1:0] prga_address,
    input  logic [DATA_W-1:0] init_data,
    input  logic [DATA_W-1:0] ksa_data,
    input  logic [DATA_W-1:0] prga_data,
    input  logic              init_wren,
    input  logic              ksa_wren,
    input  logic              prga_wren,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;
    // With TIMEOUT=0 this limit is never consulted: the watchdog is gated off entirely.
    localparam logic [CNT_W-1:0] WD_LIMIT = CNT_W'(TIMEOUT - 1);

    typedef enum logic [3:0] {
        ST_IDLE       = 4'd0,
        ST_START_INIT = 4'd1,
        ST_WAIT_INIT  = 4'd2,
        ST_START_KSA  = 4'd3,
        ST_WAIT_KSA   = 4'd4,
        ST_START_PRGA = 4'd5,
        ST_WAIT_PRGA  = 4'd6,
        ST_DONE       = 4'd7,
        ST_ERROR      = 4'd8
    } state_t;

    state_t           state_r;
    state_t           state_next_s;
    logic [CNT_W-1:0] wd_cnt_r;
    logic             in_wait_s;
    logic             wd_expired_s;

    assign in_wait_s    = (state_r == ST_WAIT_INIT) || (state_r == ST_WAIT_KSA) ||
                          (state_r == ST_WAIT_PRGA);
    assign wd_expired_s = (TIMEOUT != 0) && (wd_cnt_r == WD_LIMIT);

    // State register with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Watchdog: zero outside WAIT states, so every WAIT entry starts counting from 0.
    always_ff @(posedge clock) begin
        if (!reset) begin
            wd_cnt_r <= '0;
        end else if (TIMEOUT == 0) begin
            wd_cnt_r <= '0;
        end else if (in_wait_s) begin
            wd_cnt_r <= wd_cnt_r + CNT_W'(1'b1);
        end else begin
            wd_cnt_r <= '0;
        end
    end

    // Next-state logic; only the owning phase's finish is examined, and it beats the watchdog.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_next_s = ST_START_INIT;
                else       state_next_s = ST_IDLE;
            end
            ST_START_INIT: state_next_s = ST_WAIT_INIT;
            ST_WAIT_INIT: begin
                if (init_finish)       state_next_s = ST_START_KSA;
                else if (wd_expired_s) state_next_s = ST_ERROR;
                else                   state_next_s = ST_WAIT_INIT;
            end
            ST_START_KSA: state_next_s = ST_WAIT_KSA;
            ST_WAIT_KSA: begin
                if (ksa_finish)        state_next_s = ST_START_PRGA;
                else if (wd_expired_s) state_next_s = ST_ERROR;
                else                   state_next_s = ST_WAIT_KSA;
            end
            ST_START_PRGA: state_next_s = ST_WAIT_PRGA;
            ST_WAIT_PRGA: begin
                if (prga_finish)       state_next_s = ST_DONE;
                else if (wd_expired_s) state_next_s = ST_ERROR;
                else                   state_next_s = ST_WAIT_PRGA;
            end
            ST_DONE, ST_ERROR: begin
                if (start) state_next_s = ST_START_INIT;
                else       state_next_s = state_r;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output decode and memory-port mux; the port is idle in every non-WAIT state.
    always_comb begin
        done        = 1'b0;
        error       = 1'b0;
        phase       = 2'd0;
        init_start  = 1'b0;
        ksa_start   = 1'b0;
        prga_start  = 1'b0;
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        case (state_r)
            ST_START_INIT: init_start = 1'b1;
            ST_START_KSA:  ksa_start  = 1'b1;
            ST_START_PRGA: prga_start = 1'b1;
            ST_WAIT_INIT: begin
                phase       = 2'd1;
                mem_address = init_address;
                mem_data    = init_data;
                mem_wren    = init_wren;
            end
            ST_WAIT_KSA: begin
                phase       = 2'd2;
                mem_address = ksa_address;
                mem_data    = ksa_data;
                mem_wren    = ksa_wren;
            end
            ST_WAIT_PRGA: begin
                phase       = 2'd3;
                mem_address = prga_address;
                mem_data    = prga_data;
                mem_wren    = prga_wren;
            end
            ST_DONE:  done  = 1'b1;
            ST_ERROR: error = 1'b1;
            default: begin
                done = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_rc4_mem_sequencer.sv
// Self-checking bench for rc4_mem_sequencer: a default-TIMEOUT instance for sequencing
// and mux checks, and a TIMEOUT=16 instance sharing the same inputs for watchdog checks.
module tb_rc4_mem_sequencer;

    logic       clock = 1'b0;
    logic       reset, start;
    logic       init_finish, ksa_finish, prga_finish;
    logic [7:0] init_address, ksa_address, prga_address;
    logic [7:0] init_data, ksa_data, prga_data;
    logic       init_wren, ksa_wren, prga_wren;

    logic       done, error, init_start, ksa_start, prga_start, mem_wren;
    logic [1:0] phase;
    logic [7:0] mem_address, mem_data;

    logic       wd_done, wd_error, wd_init_start, wd_ksa_start, wd_prga_start, wd_mem_wren;
    logic [1:0] wd_phase;
    logic [7:0] wd_mem_address, wd_mem_data;

    int checks = 0;
    int errors = 0;
    logic [1:0] exp_q[$];

    always #5 clock = ~clock;

    rc4_mem_sequencer #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(1024)) dut (
        .clock(clock), .reset(reset), .start(start), .done(done), .error(error), .phase(phase),
        .init_start(init_start), .ksa_start(ksa_start), .prga_start(prga_start),
        .init_finish(init_finish), .ksa_finish(ksa_finish), .prga_finish(prga_finish),
        .init_address(init_address), .ksa_address(ksa_address), .prga_address(prga_address),
        .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren)
    );

    rc4_mem_sequencer #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut_wd (
        .clock(clock), .reset(reset), .start(start), .done(wd_done), .error(wd_error), .phase(wd_phase),
        .init_start(wd_init_start), .ksa_start(wd_ksa_start), .prga_start(wd_prga_start),
        .init_finish(init_finish), .ksa_finish(ksa_finish), .prga_finish(prga_finish),
        .init_address(init_address), .ksa_address(ksa_address), .prga_address(prga_address),
        .init_data(init_data), .ksa_data(ksa_data), .prga_data(prga_data),
        .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
        .mem_address(wd_mem_address), .mem_data(wd_mem_data), .mem_wren(wd_mem_wren)
    );

    task automatic clear_inputs();
        start = 1'b0;
        init_finish = 1'b0; ksa_finish = 1'b0; prga_finish = 1'b0;
        init_address = 8'h00; ksa_address = 8'h00; prga_address = 8'h00;
        init_data = 8'h00; ksa_data = 8'h00; prga_data = 8'h00;
        init_wren = 1'b0; ksa_wren = 1'b0; prga_wren = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset = 1'b0;
        clear_inputs();
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Returns at the negedge of the START_INIT cycle.
    task automatic kick();
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic set_finish(input int p, input logic v);
        case (p)
            1:       init_finish = v;
            2:       ksa_finish  = v;
            default: prga_finish = v;
        endcase
    endtask

    // From IDLE, returns at the negedge of the first WAIT cycle of phase `which`.
    task automatic to_wait(input int which);
        kick();
        @(negedge clock);
        for (int p = 1; p < which; p++) begin
            set_finish(p, 1'b1);
            @(negedge clock);
            set_finish(p, 1'b0);
            @(negedge clock);
        end
    endtask

    task automatic test_reset();
        @(negedge clock);
        reset = 1'b0;
        clear_inputs();
        start = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if ({done, error, phase, init_start, ksa_start, prga_start, mem_wren, mem_address, mem_data} !== 23'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {done, error, phase, init_start, ksa_start, prga_start, mem_wren, mem_address, mem_data});
        end
        checks++;
        if ({wd_done, wd_error, wd_phase, wd_init_start, wd_mem_wren} !== 6'd0) begin
            errors++;
            $display("FAIL reset_outputs_wd: got %h expected 0",
                     {wd_done, wd_error, wd_phase, wd_init_start, wd_mem_wren});
        end
        start = 1'b0;
        reset = 1'b1;
        @(negedge clock);
        #1;
        checks++;
        if (init_start !== 1'b0 || phase !== 2'd0) begin
            errors++;
            $display("FAIL reset_idle: init_start=%b phase=%0d expected 0/0", init_start, phase);
        end
    endtask

    // Full run with 256-cycle phase models; optionally init_finish held high throughout.
    task automatic test_sequence(input bit stray, input string tag);
        int cd, act, nst, got, done_cycles;
        bit prev_st, fin_now, waiting, done_exp;
        logic [1:0] exp_ph, exp_v;
        logic [16:0] exp_mem;
        apply_reset();
        init_address = 8'h11; init_data = 8'hA1; init_wren = 1'b1;
        ksa_address  = 8'h22; ksa_data  = 8'hA2; ksa_wren  = 1'b1;
        prga_address = 8'h33; prga_data = 8'hA3; prga_wren = 1'b1;
        init_finish = stray;
        cd = 0; act = 0; prev_st = 1'b0; done_exp = 1'b0; done_cycles = 0;
        exp_q.delete();
        @(negedge clock);
        start = 1'b1;
        exp_q.push_back(2'd1); exp_q.push_back(2'd2); exp_q.push_back(2'd3);
        for (int c = 0; c < 1200; c++) begin
            @(negedge clock);
            start = 1'b0;
            ksa_finish = 1'b0; prga_finish = 1'b0;
            if (!stray) init_finish = 1'b0;
            fin_now = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    fin_now = 1'b1;
                    set_finish(act, 1'b1);
                end
            end
            waiting = (cd > 0) || fin_now;
            #1;
            exp_ph = waiting ? 2'(act) : 2'd0;
            case (exp_ph)
                2'd1:    exp_mem = {1'b1, 8'h11, 8'hA1};
                2'd2:    exp_mem = {1'b1, 8'h22, 8'hA2};
                2'd3:    exp_mem = {1'b1, 8'h33, 8'hA3};
                default: exp_mem = 17'd0;
            endcase
            checks++;
            if (phase !== exp_ph) begin
                errors++;
                $display("FAIL %s phase: cycle %0d got %0d expected %0d", tag, c, phase, exp_ph);
            end
            checks++;
            if ({mem_wren, mem_address, mem_data} !== exp_mem) begin
                errors++;
                $display("FAIL %s mem_port: cycle %0d got %h expected %h", tag, c,
                         {mem_wren, mem_address, mem_data}, exp_mem);
            end
            checks++;
            if (done !== done_exp) begin
                errors++;
                $display("FAIL %s done: cycle %0d got %b expected %b", tag, c, done, done_exp);
            end
            nst = int'(init_start) + int'(ksa_start) + int'(prga_start);
            if (nst != 0) begin
                got = init_start ? 1 : (ksa_start ? 2 : 3);
                checks++;
                if (prev_st || nst != 1) begin
                    errors++;
                    $display("FAIL %s start_shape: cycle %0d got count=%0d prev=%b expected single pulse",
                             tag, c, nst, prev_st);
                end
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s start_order: got unexpected start %0d expected none", tag, got);
                end else begin
                    exp_v = exp_q.pop_front();
                    if (got != int'(exp_v)) begin
                        errors++;
                        $display("FAIL %s start_order: got %0d expected %0d", tag, got, exp_v);
                    end
                end
                act = got;
                cd  = (stray && got == 1) ? 1 : 256;
            end
            prev_st = (nst != 0);
            if (fin_now && act == 3) done_exp = 1'b1;
            if (done_exp) done_cycles++;
            if (done_cycles >= 5) break;
        end
        checks++;
        if (done_cycles < 5 || exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s completion: got done_cycles=%0d pending=%0d expected 5/0",
                     tag, done_cycles, exp_q.size());
        end
        clear_inputs();
    endtask

    task automatic test_mux_isolation();
        apply_reset();
        kick();
        init_wren = 1'b1; init_address = 8'h55;
        #1;
        checks++;
        if (init_start !== 1'b1 || mem_wren !== 1'b0) begin
            errors++;
            $display("FAIL mux_start_init: init_start=%b mem_wren=%b expected 1/0", init_start, mem_wren);
        end
        @(negedge clock);
        init_finish = 1'b1;
        #1;
        checks++;
        if (phase !== 2'd1 || mem_address !== 8'h55 || mem_wren !== 1'b1) begin
            errors++;
            $display("FAIL mux_init_owner: phase=%0d addr=%h wren=%b expected 1/55/1", phase, mem_address, mem_wren);
        end
        @(negedge clock);
        init_finish = 1'b0;
        ksa_wren = 1'b1; ksa_address = 8'hA3; ksa_data = 8'h3C;
        #1;
        checks++;
        if (ksa_start !== 1'b1 || mem_wren !== 1'b0 || mem_address !== 8'h00 || phase !== 2'd0) begin
            errors++;
            $display("FAIL mux_start_ksa: ksa_start=%b wren=%b addr=%h phase=%0d expected 1/0/00/0",
                     ksa_start, mem_wren, mem_address, phase);
        end
        @(negedge clock);
        #1;
        checks++;
        if (mem_address !== 8'hA3 || mem_data !== 8'h3C || mem_wren !== 1'b1 || phase !== 2'd2) begin
            errors++;
            $display("FAIL mux_ksa_owner: addr=%h data=%h wren=%b phase=%0d expected A3/3C/1/2",
                     mem_address, mem_data, mem_wren, phase);
        end
        ksa_wren = 1'b0;
        #1;
        checks++;
        if (mem_wren !== 1'b0 || mem_address !== 8'hA3) begin
            errors++;
            $display("FAIL mux_non_owner_wren: wren=%b addr=%h expected 0/A3", mem_wren, mem_address);
        end
        clear_inputs();
    endtask

    task automatic test_watchdog();
        apply_reset();
        to_wait(2);
        ksa_wren = 1'b1; ksa_address = 8'h5A; ksa_data = 8'hC3;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if (wd_error !== 1'b0 || wd_phase !== 2'd2 || wd_prga_start !== 1'b0) begin
                errors++;
                $display("FAIL wd_early: cycle %0d error=%b phase=%0d prga_start=%b expected 0/2/0",
                         i, wd_error, wd_phase, wd_prga_start);
            end
        end
        @(negedge clock);
        #1;
        checks++;
        if (wd_error !== 1'b1 || wd_done !== 1'b0 || wd_phase !== 2'd0) begin
            errors++;
            $display("FAIL wd_fire: error=%b done=%b phase=%0d expected 1/0/0", wd_error, wd_done, wd_phase);
        end
        checks++;
        if (wd_mem_wren !== 1'b0 || wd_mem_address !== 8'h00 || wd_mem_data !== 8'h00) begin
            errors++;
            $display("FAIL wd_port_idle: wren=%b addr=%h data=%h expected 0/00/00",
                     wd_mem_wren, wd_mem_address, wd_mem_data);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if (wd_prga_start !== 1'b0 || wd_error !== 1'b1) begin
                errors++;
                $display("FAIL wd_hold: cycle %0d prga_start=%b error=%b expected 0/1", i, wd_prga_start, wd_error);
            end
        end
        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        #1;
        checks++;
        if (wd_init_start !== 1'b1 || wd_error !== 1'b0) begin
            errors++;
            $display("FAIL wd_restart: init_start=%b error=%b expected 1/0", wd_init_start, wd_error);
        end
        apply_reset();
        to_wait(2);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge clock);
            if (i == 15) ksa_finish = 1'b1;
            #1;
            checks++;
            if (wd_error !== 1'b0) begin
                errors++;
                $display("FAIL wd_late_finish_wait: cycle %0d error=%b expected 0", i, wd_error);
            end
        end
        @(negedge clock);
        ksa_finish = 1'b0;
        #1;
        checks++;
        if (wd_prga_start !== 1'b1 || wd_error !== 1'b0) begin
            errors++;
            $display("FAIL wd_finish_wins: prga_start=%b error=%b expected 1/0", wd_prga_start, wd_error);
        end
        clear_inputs();
    endtask

    task automatic test_restart();
        apply_reset();
        to_wait(1);
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clock);
            #1;
            checks++;
            if (init_start !== 1'b0 || phase !== 2'd1) begin
                errors++;
                $display("FAIL restart_ignored: cycle %0d init_start=%b phase=%0d expected 0/1", i, init_start, phase);
            end
        end
        @(negedge clock);
        start = 1'b0;
        init_finish = 1'b1;
        @(negedge clock);
        init_finish = 1'b0;
        @(negedge clock);
        ksa_finish = 1'b1;
        @(negedge clock);
        ksa_finish = 1'b0;
        @(negedge clock);
        prga_finish = 1'b1;
        #1;
        checks++;
        if (done !== 1'b0 || phase !== 2'd3) begin
            errors++;
            $display("FAIL restart_prga_wait: done=%b phase=%0d expected 0/3", done, phase);
        end
        @(negedge clock);
        prga_finish = 1'b0;
        #1;
        checks++;
        if (done !== 1'b1 || phase !== 2'd0) begin
            errors++;
            $display("FAIL restart_done: done=%b phase=%0d expected 1/0", done, phase);
        end
        @(negedge clock);
        start = 1'b1;
        #1;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL restart_done_held: done=%b expected 1", done);
        end
        @(negedge clock);
        start = 1'b0;
        #1;
        checks++;
        if (init_start !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL restart_from_done: init_start=%b done=%b expected 1/0", init_start, done);
        end
        @(negedge clock);
        #1;
        checks++;
        if (init_start !== 1'b0 || phase !== 2'd1) begin
            errors++;
            $display("FAIL restart_single_pulse: init_start=%b phase=%0d expected 0/1", init_start, phase);
        end
        clear_inputs();
    endtask

    task automatic test_midrun_reset();
        apply_reset();
        to_wait(3);
        prga_wren = 1'b1; prga_address = 8'h77; prga_data = 8'h99;
        #1;
        checks++;
        if (mem_wren !== 1'b1 || mem_address !== 8'h77 || phase !== 2'd3) begin
            errors++;
            $display("FAIL midrun_prga_owner: wren=%b addr=%h phase=%0d expected 1/77/3", mem_wren, mem_address, phase);
        end
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        #1;
        checks++;
        if (phase !== 2'd0 || mem_wren !== 1'b0 || done !== 1'b0 || mem_address !== 8'h00) begin
            errors++;
            $display("FAIL midrun_after_reset: phase=%0d wren=%b done=%b addr=%h expected 0/0/0/00",
                     phase, mem_wren, done, mem_address);
        end
        prga_finish = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            #1;
            checks++;
            if ({init_start, ksa_start, prga_start, done, phase} !== 5'd0) begin
                errors++;
                $display("FAIL midrun_idle: cycle %0d starts/done/phase=%b expected 00000",
                         i, {init_start, ksa_start, prga_start, done, phase});
            end
        end
        prga_finish = 1'b0;
        kick();
        #1;
        checks++;
        if (init_start !== 1'b1) begin
            errors++;
            $display("FAIL midrun_new_start: init_start=%b expected 1", init_start);
        end
        clear_inputs();
    endtask

    initial begin
        reset = 1'b0;
        clear_inputs();
        test_reset();
        test_sequence(1'b0, "nominal");
        test_mux_isolation();
        test_watchdog();
        test_restart();
        test_midrun_reset();
        test_sequence(1'b1, "stray_finish");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
